uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin packet arbiter sharing one UART TX AXI-stream input among CH_NUM requesters.
//  Sits between the producer channels and the UART s_axis_* port; m_axis_* connects directly to it.
//  Holds the grant for a whole packet (until tlast) or for at most MAX_BURST bytes.
//  When HDR_EN=1, prefixes every grant with a header byte (HDR_BASE + channel index) so the receiver can demux.
// PARAMETERS
//  CH_NUM     4      number of requester channels, 2..8
//  DATA_BITS  8      byte width; must match the UART data_bits
//  HDR_EN     1      1: emit a header byte per grant; 0: pure pass-through
//  HDR_BASE   8'hA0  header value for ch0; header = HDR_BASE + ch, truncated to DATA_BITS
//  MAX_BURST  16     max payload bytes per grant; 0 = unlimited (release only on tlast)
// PORTS
//  clk            in   1                 system clock
//  rst            in   1                 synchronous, active-high reset
//  s_axis_tdata   in   CH_NUM*DATA_BITS  channel data; ch k occupies bits [k*DATA_BITS +: DATA_BITS]
//  s_axis_tvalid  in   CH_NUM            per-channel valid
//  s_axis_tlast   in   CH_NUM            per-channel end-of-packet
//  s_axis_tready  out  CH_NUM            per-channel ready
//  m_axis_tdata   out  DATA_BITS         byte to the UART TX
//  m_axis_tvalid  out  1                 valid to the UART TX
//  m_axis_tready  in   1                 ready from the UART TX (its s_axis_tready)
//  grant          out  CH_NUM            one-hot current owner; 0 when idle
//  busy           out  1                 1 in state HDR or DATA
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; grant=0; burst count=0; last_grant=CH_NUM-1, so ch0 has first priority.
//    Combinational outputs follow: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, busy=0.
//  - FSM states: IDLE, HDR, DATA.
//  - IDLE:
//    - If any s_axis_tvalid bit is set, pick the first set bit searching from last_grant+1 upward, modulo CH_NUM.
//    - Latch the pick into grant and last_grant, clear the count, then go to HDR (HDR_EN=1) or DATA (HDR_EN=0).
//    - Arbitration costs 1 cycle, which leaves 1 dead cycle between grants.
//  - HDR:
//    - m_axis_tvalid=1 and m_axis_tdata=HDR_BASE+g, where g is the granted channel; all s_axis_tready=0.
//    - On m_axis_tready=1, go to DATA. Otherwise hold, with the header stable.
//  - DATA (combinational pass-through, 0 latency):
//    - m_axis_tdata = channel g data; m_axis_tvalid = s_axis_tvalid[g].
//    - s_axis_tready[g] = m_axis_tready; all other tready bits = 0.
//    - Transfer = m_axis_tvalid & m_axis_tready; each transfer increments the count.
//    - End of grant = transfer AND (s_axis_tlast[g] OR (MAX_BURST!=0 AND count==MAX_BURST-1)).
//      At end of grant: go to IDLE and clear grant next cycle.
//    - A channel dropping tvalid mid-packet keeps the grant; there is no timeout.
//  - A burst-limit release does not end the packet: the remainder resumes at that channel's next grant, with a new header.
//  - Requests arriving during HDR/DATA wait. Simultaneous requests are resolved only by the round-robin order.
//  - Once asserted, m_axis_tvalid never drops without a transfer, in HDR and in DATA, given producers that are AXI-compliant.
//  - rst mid-grant aborts immediately; any byte already accepted by the UART is not recalled.
// TESTING
//  1. HDR_EN=1, ch2 sends 8'h11 then 8'h22(last), m_tready=1
//     -> m stream A2,11,22; grant=4'b0100 for 3 cycles; then busy=0.
//  2. All 4 channels send 1-byte packets D0..D3 (last=1) at the same cycle after reset
//     -> A0,D0,A1,D1,A2,D2,A3,D3 in that order.
//  3. m_axis_tready=0 for 5 cycles while in HDR for ch1
//     -> tvalid=1 and tdata=A1 held all 5 cycles; s_axis_tready=0.
//  4. MAX_BURST=4; ch1 sends 6 bytes B0..B5 (last on B5) while ch3 holds a 1-byte C0
//     -> A1,B0..B3,A3,C0,A1,B4,B5.
//  5. rst=1 for 1 cycle after ch0's 2nd data byte
//     -> next cycle m_tvalid=0, grant=0, busy=0; after release, ch0 wins the tie against ch1.
//  6. HDR_EN=0; ch0 3-byte packet with ch1 valid throughout
//     -> ch0 bytes uninterrupted; ch1 granted 1 idle cycle later.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// AXI-stream bundle around the UART TX arbiter: CH_NUM producer lanes in, one byte lane out.
interface uart_tx_arbiter_if #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned DATA_BITS = 8
);
    logic [CH_NUM*DATA_BITS-1:0] s_axis_tdata;
    logic [CH_NUM-1:0]           s_axis_tvalid;
    logic [CH_NUM-1:0]           s_axis_tlast;
    logic [CH_NUM-1:0]           s_axis_tready;
    logic [DATA_BITS-1:0]        m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART TX stream from CH_NUM producers,
// optionally prefixing each grant with a channel header byte.
module uart_tx_arbiter #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter bit          HDR_EN    = 1'b1,
    parameter int unsigned HDR_BASE  = 'hA0,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  axis,
    output logic [CH_NUM-1:0] grant,
    output logic              busy
);
    localparam int unsigned IDX_W      = $clog2(CH_NUM);
    localparam int unsigned CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned BURST_LAST = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t             state_q, state_d;
    logic [CH_NUM-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic [DATA_BITS-1:0] sel_data;
    logic [DATA_BITS-1:0] hdr_byte;
    logic [DATA_BITS-1:0] m_data;
    logic               m_valid;
    logic [CH_NUM-1:0]  s_ready;

    // Search starts just after the previous owner, so last_q doubles as the rotation pointer.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            idx = IDX_W'((32'(last_q) + i) % CH_NUM);
            if (!found && axis.s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign sel_data = DATA_BITS'(axis.s_axis_tdata >> (DATA_BITS * 32'(last_q)));
    assign hdr_byte = DATA_BITS'(HDR_BASE + 32'(last_q));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        m_data  = '0;
        m_valid = 1'b0;
        s_ready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = CH_NUM'(1) << pick;
                    last_d  = pick;
                    count_d = '0;
                    state_d = HDR_EN ? HDR : DATA;
                end
            end
            HDR: begin
                m_valid = 1'b1;
                m_data  = hdr_byte;
                if (axis.m_axis_tready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_data  = sel_data;
                m_valid = axis.s_axis_tvalid[last_q];
                s_ready = grant_q & {CH_NUM{axis.m_axis_tready}};
                if (m_valid && axis.m_axis_tready) begin
                    count_d = count_q + 1'b1;
                    // Burst limit releases the grant mid-packet; the rest resumes with a fresh header.
                    if (axis.s_axis_tlast[last_q] ||
                        ((MAX_BURST != 0) && (count_q == CNT_W'(BURST_LAST)))) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(CH_NUM - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign axis.m_axis_tdata  = m_data;
    assign axis.m_axis_tvalid = m_valid;
    assign axis.s_axis_tready = s_ready;
    assign grant              = grant_q;
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: dut_a (headers, burst limit 4) and dut_b (no headers) fed by queued producers.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.CH_NUM(4), .DATA_BITS(8)) if_a ();
    uart_tx_arbiter_if #(.CH_NUM(4), .DATA_BITS(8)) if_b ();
    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    uart_tx_arbiter #(.CH_NUM(4), .DATA_BITS(8), .HDR_EN(1'b1), .HDR_BASE('hA0), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .axis(if_a.slave), .grant(grant_a), .busy(busy_a));
    uart_tx_arbiter #(.CH_NUM(4), .DATA_BITS(8), .HDR_EN(1'b0), .HDR_BASE('hA0), .MAX_BURST(16)) dut_b (
        .clk(clk), .rst(rst), .axis(if_b.slave), .grant(grant_b), .busy(busy_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Producer buffers: {last, data}, one FIFO per dut/channel.
    logic [8:0]  sbuf [2][4][64];
    int unsigned wr   [2][4];
    int unsigned rd   [2][4];
    logic        rst_req = 1'b1;
    logic [1:0]  rdy_req = 2'b11;
    logic [3:0]  fire   [2];
    logic [31:0] vd [2];
    logic [3:0]  vv [2];
    logic [3:0]  vl [2];

    logic [11:0] exp_a [$];
    logic [11:0] exp_b [$];

    task automatic push(input int d, input int k, input logic [7:0] b, input logic l);
        sbuf[d][k][wr[d][k]] = {l, b};
        wr[d][k]++;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always begin
        @(negedge clk);
        fire[0] = if_a.s_axis_tvalid & if_a.s_axis_tready;
        fire[1] = if_b.s_axis_tvalid & if_b.s_axis_tready;
        @(posedge clk);
        #1;
        rst = rst_req;
        if_a.m_axis_tready = rdy_req[0];
        if_b.m_axis_tready = rdy_req[1];
        for (int d = 0; d < 2; d++) begin
            vd[d] = '0;
            vv[d] = '0;
            vl[d] = '0;
            for (int k = 0; k < 4; k++) begin
                if (fire[d][k] === 1'b1) rd[d][k]++;
                if (rd[d][k] < wr[d][k]) begin
                    vv[d][k]       = 1'b1;
                    vd[d][k*8 +: 8] = sbuf[d][k][rd[d][k]][7:0];
                    vl[d][k]       = sbuf[d][k][rd[d][k]][8];
                end
            end
        end
        if_a.s_axis_tdata  = vd[0];
        if_a.s_axis_tvalid = vv[0];
        if_a.s_axis_tlast  = vl[0];
        if_b.s_axis_tdata  = vd[1];
        if_b.s_axis_tvalid = vv[1];
        if_b.s_axis_tlast  = vl[1];
    end

    logic [11:0] ea, eb;
    always @(negedge clk) begin
        if (if_a.m_axis_tvalid === 1'b1 && if_a.m_axis_tready === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected", {24'd0, if_a.m_axis_tdata}, 32'hFFFF_FFFF);
            end else begin
                ea = exp_a.pop_front();
                check("a_data", {24'd0, if_a.m_axis_tdata}, {24'd0, ea[7:0]});
                check("a_grant", {28'd0, grant_a}, {28'd0, ea[11:8]});
            end
        end
        if (if_b.m_axis_tvalid === 1'b1 && if_b.m_axis_tready === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", {24'd0, if_b.m_axis_tdata}, 32'hFFFF_FFFF);
            end else begin
                eb = exp_b.pop_front();
                check("b_data", {24'd0, if_b.m_axis_tdata}, {24'd0, eb[7:0]});
                check("b_grant", {28'd0, grant_b}, {28'd0, eb[11:8]});
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int i;
        i = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && i < budget) begin
            step();
            i++;
        end
        check(tag, exp_a.size() + exp_b.size(), 0);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        step();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, {28'd0, grant_a}, 0);
        check({tag, "_busy"}, {31'd0, busy_a}, 0);
        check({tag, "_mvalid"}, {31'd0, if_a.m_axis_tvalid}, 0);
        check({tag, "_sready"}, {28'd0, if_a.s_axis_tready}, 0);
    endtask

    initial begin
        step();
        step();
        check_idle("reset");
        check("reset_mdata", {24'd0, if_a.m_axis_tdata}, 0);
        check("reset_b_grant", {28'd0, grant_b}, 0);
        check("reset_b_busy", {31'd0, busy_b}, 0);
        rst_req = 1'b0;
        step();
        step();

        // single packet on ch2
        push(0, 2, 8'h11, 1'b0);
        push(0, 2, 8'h22, 1'b1);
        exp_a.push_back({4'b0100, 8'hA2});
        exp_a.push_back({4'b0100, 8'h11});
        exp_a.push_back({4'b0100, 8'h22});
        wait_drain("t1_drain", 50);
        step();
        check_idle("t1_after");

        // simultaneous 1-byte packets on all channels
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, k, 8'(8'hD0 + k), 1'b1);
            exp_a.push_back({4'(1 << k), 8'(8'hA0 + k)});
            exp_a.push_back({4'(1 << k), 8'(8'hD0 + k)});
        end
        wait_drain("t2_drain", 100);

        // header held under backpressure
        rdy_req[0] = 1'b0;
        push(0, 1, 8'h33, 1'b1);
        exp_a.push_back({4'b0010, 8'hA1});
        exp_a.push_back({4'b0010, 8'h33});
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            check("t3_mvalid", {31'd0, if_a.m_axis_tvalid}, 1);
            check("t3_mdata", {24'd0, if_a.m_axis_tdata}, 32'hA1);
            check("t3_sready", {28'd0, if_a.s_axis_tready}, 0);
        end
        rdy_req[0] = 1'b1;
        wait_drain("t3_drain", 50);

        // burst limit splits a 6-byte packet around another channel
        do_reset();
        for (int i = 0; i < 6; i++) push(0, 1, 8'(8'hB0 + i), (i == 5));
        push(0, 3, 8'hC0, 1'b1);
        exp_a.push_back({4'b0010, 8'hA1});
        for (int i = 0; i < 4; i++) exp_a.push_back({4'b0010, 8'(8'hB0 + i)});
        exp_a.push_back({4'b1000, 8'hA3});
        exp_a.push_back({4'b1000, 8'hC0});
        exp_a.push_back({4'b0010, 8'hA1});
        exp_a.push_back({4'b0010, 8'hB4});
        exp_a.push_back({4'b0010, 8'hB5});
        wait_drain("t4_drain", 200);

        // reset mid-grant, then ch0 wins the tie
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 0, 8'(8'hE0 + i), (i == 3));
        push(0, 1, 8'hF0, 1'b1);
        exp_a.push_back({4'b0001, 8'hA0});
        exp_a.push_back({4'b0001, 8'hE0});
        exp_a.push_back({4'b0001, 8'hE1});
        exp_a.push_back({4'b0001, 8'hA0});
        exp_a.push_back({4'b0001, 8'hE2});
        exp_a.push_back({4'b0001, 8'hE3});
        exp_a.push_back({4'b0010, 8'hA1});
        exp_a.push_back({4'b0010, 8'hF0});
        for (int c = 0; c < 4; c++) step();
        rst_req    = 1'b1;
        rdy_req[0] = 1'b0;
        step();
        rst_req    = 1'b0;
        rdy_req[0] = 1'b1;
        step();
        check_idle("t5_rst");
        wait_drain("t5_drain", 100);

        // pass-through: ch0 packet uninterrupted, ch1 one idle cycle later
        push(1, 0, 8'h61, 1'b0);
        push(1, 0, 8'h62, 1'b0);
        push(1, 0, 8'h63, 1'b1);
        push(1, 1, 8'h71, 1'b1);
        exp_b.push_back({4'b0001, 8'h61});
        exp_b.push_back({4'b0001, 8'h62});
        exp_b.push_back({4'b0001, 8'h63});
        exp_b.push_back({4'b0010, 8'h71});
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("t6_mvalid", {31'd0, if_b.m_axis_tvalid}, 1);
            check("t6_grant0", {28'd0, grant_b}, 32'b0001);
        end
        step();
        check("t6_gap_grant", {28'd0, grant_b}, 0);
        check("t6_gap_busy", {31'd0, busy_b}, 0);
        step();
        check("t6_grant1", {28'd0, grant_b}, 32'b0010);
        wait_drain("t6_drain", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
